// File: rtl/cmd_pkg.sv
// Shared definitions for the host/copter command link: opcodes, the
// positive-acknowledge byte and the initiator-side FSM states.
package cmd_pkg;

  typedef enum logic [7:0] {
    OP_PITCH     = 8'h02,
    OP_ROLL      = 8'h03,
    OP_YAW       = 8'h04,
    OP_THRUST    = 8'h05,
    OP_CALIBRATE = 8'h06,
    OP_EMER_LAND = 8'h07,
    OP_MOTORS_OFF = 8'h08
  } opcode_t;

  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_HI,
    TX_LO,
    WAIT_RESP
  } state_t;

endpackage

// File: rtl/remote_cmd_tx_resp_tmr.sv
// Clearable saturating counter; expired is high once the count sits at
// TERM_CNT-1, and it stays there until cleared.
module resp_tmr #(
  parameter int TERM_CNT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(TERM_CNT);
  localparam logic [W-1:0] LAST = W'(TERM_CNT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/remote_cmd_tx.sv
// Command initiator: sends opcode, data[15:8], data[7:0] over a byte UART,
// then waits (with timeout) for the copter's single response byte.
module remote_cmd_tx
  import cmd_pkg::*;
#(
  parameter int          TIMEOUT = 4096,
  parameter logic [7:0]  POS_ACK = cmd_pkg::POS_ACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        ack,
  output logic        timeout,
  output state_t      dbg_state
);

  state_t      state;
  logic [15:0] data_q;
  logic        expired;
  logic        tmr_clr;

  // Timer runs only while waiting; leaving TX_LO therefore starts it at zero.
  assign tmr_clr   = (state != WAIT_RESP);
  assign dbg_state = state;

  resp_tmr #(.TERM_CNT(TIMEOUT)) u_resp_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      busy       <= 1'b0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      clr_rx_rdy <= 1'b0;
      resp       <= 8'h00;
      resp_rdy   <= 1'b0;
      ack        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp_rdy   <= 1'b0;
      case (state)
        IDLE: begin
          // Acceptance also flushes any stale byte left in the receiver.
          if (snd_cmd) begin
            data_q     <= data;
            tx_data    <= cmd;
            trmt       <= 1'b1;
            busy       <= 1'b1;
            clr_rx_rdy <= 1'b1;
            ack        <= 1'b0;
            timeout    <= 1'b0;
            state      <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (tx_done) begin
            trmt    <= 1'b1;
            tx_data <= data_q[15:8];
            state   <= TX_HI;
          end
        end
        TX_HI: begin
          if (tx_done) begin
            trmt    <= 1'b1;
            tx_data <= data_q[7:0];
            state   <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_done) begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A byte arriving on the expiry cycle still counts as a response.
          if (rx_rdy) begin
            resp       <= rx_data;
            ack        <= (rx_data == POS_ACK);
            timeout    <= 1'b0;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (expired) begin
            timeout  <= 1'b1;
            ack      <= 1'b0;
            resp_rdy <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Bench for remote_cmd_tx: scoreboarded byte stream and response records,
// with a behavioural UART transmitter answering each trmt after 10 cycles.
module tb_remote_cmd_tx;
  import cmd_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        ack;
  logic        timeout;
  state_t      dbg_state;

  remote_cmd_tx #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .snd_cmd    (snd_cmd),
    .cmd        (cmd),
    .data       (data),
    .busy       (busy),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .resp       (resp),
    .resp_rdy   (resp_rdy),
    .ack        (ack),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  // response record: {expected cycle[15:0], resp[7:0], ack, timeout}
  logic [25:0] resp_q[$];
  int done_cnt      = 0;
  int last_done_cyc = 0;
  int resp_cnt      = 0;
  int dn_target     = 0;
  logic [7:0] last_resp = 8'h00;
  logic [7:0]  mon_b;
  logic [25:0] mon_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (trmt) begin
      check("tx_busy", busy, 1);
      check("tx_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_b = exp_q.pop_front();
        check("tx_byte", tx_data, mon_b);
      end
    end
    if (resp_rdy) begin
      resp_cnt++;
      check("resp_q_nonempty", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) begin
        mon_r = resp_q.pop_front();
        check("resp_cycle", cyc[15:0], mon_r[25:10]);
        check("resp", resp, mon_r[9:2]);
        check("ack", ack, mon_r[1]);
        check("timeout", timeout, mon_r[0]);
        check("resp_clr", clr_rx_rdy, !mon_r[0]);
        check("resp_busy", busy, 0);
      end
    end
  end

  // ---------------- UART transmitter model ----------------
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt) begin
        repeat (10) @(posedge clk);
        #1 tx_done = 1'b1;
        last_done_cyc = cyc;
        done_cnt++;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    snd_cmd = 1'b1;
    cmd     = c;
    data    = d;
    exp_q.push_back(c);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    dn_target += 3;
    @(posedge clk);
    #1 snd_cmd = 1'b0;
    @(negedge clk);
    check("acc_trmt", trmt, 1);
    check("acc_busy", busy, 1);
    check("acc_clr", clr_rx_rdy, 1);
    check("acc_ack_clr", ack, 0);
    check("acc_to_clr", timeout, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < dn_target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tx_done_seen", done_cnt, dn_target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("resp_seen", resp_cnt, target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic respond(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    resp_q.push_back({16'(cyc + 1), b, (b == 8'hA5), 1'b0});
    last_resp = b;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    snd_cmd = 1'b0;
    cmd     = 8'h00;
    data    = 16'h0000;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_trmt", trmt, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_clr", clr_rx_rdy, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_ack", ack, 0);
    check("rst_timeout", timeout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // positive acknowledge, 5 cycles after the last tx_done
    send_cmd(8'h02, 16'h1234);
    wait_done();
    repeat (4) begin @(posedge clk); #1; end
    respond(8'hA5);
    wait_resp(1);

    // negative response
    send_cmd(8'h03, 16'hABCD);
    wait_done();
    repeat (4) begin @(posedge clk); #1; end
    respond(8'h5A);
    wait_resp(2);

    // no response: timeout 17 cycles after the last tx_done, resp held
    send_cmd(8'h04, 16'h0F0F);
    wait_done();
    resp_q.push_back({16'(last_done_cyc + 17), last_resp, 1'b0, 1'b1});
    wait_resp(3);

    // response on the expiry cycle, then a new command in the resp_rdy cycle
    send_cmd(8'h07, 16'h00FF);
    wait_done();
    wait_cyc(last_done_cyc + 16);
    respond(8'hA5);
    send_cmd(8'h08, 16'h5555);
    wait_resp(4);
    wait_done();
    repeat (2) begin @(posedge clk); #1; end
    respond(8'h33);
    wait_resp(5);

    // command while busy is ignored; reset while waiting aborts
    send_cmd(8'h02, 16'h1234);
    for (int i = 0; i < 100 && done_cnt < dn_target - 2; i++) @(negedge clk);
    repeat (2) begin @(posedge clk); #1; end
    snd_cmd = 1'b1;
    cmd     = 8'h05;
    data    = 16'h01FF;
    @(posedge clk);
    #1 snd_cmd = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 1);
    check("ign_state", dbg_state, TX_HI);
    wait_done();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_state", dbg_state, WAIT_RESP);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_state", dbg_state, IDLE);
    check("abort_busy", busy, 0);
    check("abort_tx_data", tx_data, 8'h00);
    check("abort_resp", resp, 8'h00);
    check("abort_ack", ack, 0);
    check("abort_timeout", timeout, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("no_resp_after_rst", resp_cnt, 5);
    check("tx_q_drained", exp_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
